// File: rtl/bit_index_serializer_if.sv
// Request/beat bus for bit_index_serializer.
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid and ready are both 1. A source holds valid and its payload
// stable until that transfer; ready may change at any time and never waits on
// the same channel's next valid.
interface bit_index_serializer_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_pos;
  logic [1:0] out_seq;
  logic       out_last;
  logic       out_empty;

  // Upstream producer and downstream consumer side, seen from outside the block
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_pos, out_seq, out_last, out_empty
  );

  // The serializer itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_pos, out_seq, out_last, out_empty
  );
endinterface

// File: rtl/bit_index_serializer.sv
// Turns a 4-bit request vector into one beat per set bit, lowest index first.
// Each beat carries the bit index, a beat number and a last flag. A new vector
// may be accepted in the same cycle the previous vector's last beat leaves.
module bit_index_serializer #(
  parameter bit EMIT_EMPTY = 1'b0
) (
  input  logic                         clk,
  input  logic                         resetn,
  bit_index_serializer_if.slave        bus,
  output logic                         busy,
  output logic [0:0]                   dbg_state
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  logic [0:0] state_q, state_d;
  logic [3:0] mask_q, mask_d;
  logic [1:0] seq_q, seq_d;
  logic       empty_q, empty_d;

  logic [3:0] mask_minus_one;
  logic [1:0] low_pos;
  logic       single_bit;
  logic       out_fire;
  logic       in_fire;

  // Lowest set bit of the remaining mask, and whether only one bit remains
  always_comb begin
    mask_minus_one = mask_q - 4'd1;
    single_bit     = (mask_q != 4'd0) && ((mask_q & mask_minus_one) == 4'd0);
    low_pos        = 2'd0;
    if (mask_q[0])      low_pos = 2'd0;
    else if (mask_q[1]) low_pos = 2'd1;
    else if (mask_q[2]) low_pos = 2'd2;
    else if (mask_q[3]) low_pos = 2'd3;
  end

  // Outputs are pure decodes of the registers; in_ready also looks through to
  // a last-beat handshake so back-to-back vectors need no idle cycle
  always_comb begin
    bus.out_valid = (state_q == ST_EMIT);
    bus.out_pos   = low_pos;
    bus.out_seq   = seq_q;
    bus.out_last  = empty_q | single_bit;
    bus.out_empty = empty_q;
    busy          = (state_q == ST_EMIT);
    dbg_state     = state_q;
    out_fire      = bus.out_valid & bus.out_ready;
    bus.in_ready  = (state_q == ST_IDLE) | (out_fire & bus.out_last);
    in_fire       = bus.in_valid & bus.in_ready;
  end

  // Next-state: beat consumption first, then a same-cycle accept overrides it
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    seq_d   = seq_q;
    empty_d = empty_q;

    if (out_fire) begin
      if (bus.out_last) begin
        state_d = ST_IDLE;
        mask_d  = 4'd0;
        seq_d   = 2'd0;
        empty_d = 1'b0;
      end else begin
        mask_d = mask_q & mask_minus_one;
        seq_d  = seq_q + 2'd1;
      end
    end

    if (in_fire) begin
      seq_d = 2'd0;
      if (bus.in_data != 4'd0) begin
        state_d = ST_EMIT;
        mask_d  = bus.in_data;
        empty_d = 1'b0;
      end else if (EMIT_EMPTY) begin
        state_d = ST_EMIT;
        mask_d  = 4'd0;
        empty_d = 1'b1;
      end else begin
        // Empty vector swallowed: nothing to emit
        state_d = ST_IDLE;
        mask_d  = 4'd0;
        empty_d = 1'b0;
      end
    end
  end

  // State registers; reset discards any vector in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      mask_q  <= 4'd0;
      seq_q   <= 2'd0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      seq_q   <= seq_d;
      empty_q <= empty_d;
    end
  end

endmodule

// File: tb/tb_bit_index_serializer.sv
// Bench for bit_index_serializer: one instance with EMIT_EMPTY=0 and one with
// EMIT_EMPTY=1 share the stimulus signals; sel picks which one is exercised.
module tb_bit_index_serializer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  bit_index_serializer_if if0 ();
  bit_index_serializer_if if1 ();
  logic       busy0, busy1;
  logic [0:0] dbg0, dbg1;

  bit_index_serializer #(.EMIT_EMPTY(1'b0)) dut0 (
    .clk(clk), .resetn(resetn), .bus(if0.slave), .busy(busy0), .dbg_state(dbg0)
  );
  bit_index_serializer #(.EMIT_EMPTY(1'b1)) dut1 (
    .clk(clk), .resetn(resetn), .bus(if1.slave), .busy(busy1), .dbg_state(dbg1)
  );

  // ---------------- shared stimulus, routed by sel ----------------
  logic       sel = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       out_ready = 1'b1;

  assign if0.in_valid  = in_valid & ~sel;
  assign if0.in_data   = in_data;
  assign if0.out_ready = sel ? 1'b1 : out_ready;
  assign if1.in_valid  = in_valid & sel;
  assign if1.in_data   = in_data;
  assign if1.out_ready = sel ? out_ready : 1'b1;

  logic       o_valid, o_in_ready, o_last, o_empty, o_busy, o_dbg;
  logic [1:0] o_pos, o_seq;
  assign o_valid    = sel ? if1.out_valid : if0.out_valid;
  assign o_in_ready = sel ? if1.in_ready  : if0.in_ready;
  assign o_pos      = sel ? if1.out_pos   : if0.out_pos;
  assign o_seq      = sel ? if1.out_seq   : if0.out_seq;
  assign o_last     = sel ? if1.out_last  : if0.out_last;
  assign o_empty    = sel ? if1.out_empty : if0.out_empty;
  assign o_busy     = sel ? busy1 : busy0;
  assign o_dbg      = sel ? dbg1[0] : dbg0[0];

  // ---------------- scoreboard ----------------
  // Beat encoding {empty, last, seq[1:0], pos[1:0]}
  logic [5:0] exp_q[$];
  logic [5:0] log_q[$];
  int n_cmp = 0;
  int n_err = 0;
  logic accepted;
  bit   rand_ready = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (sel=%0d t=%0t)", tag, obs, exp, sel, $time);
    end
  endtask

  // Reference: walk the vector's bits upward, one beat per set bit
  task automatic model_push(input logic [3:0] v, input bit emit_empty);
    int cnt;
    int k;
    cnt = $countones(v);
    k = 0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        exp_q.push_back({1'b0, (k == cnt - 1), 2'(k), 2'(i)});
        k++;
      end
    end
    if (v == 4'd0 && emit_empty) exp_q.push_back(6'b11_00_00);
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge with inputs set; checks, then clocks once
  task automatic tick();
    logic       ev, er;
    logic [5:0] b;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    #1;
    ev = (exp_q.size() != 0);
    b  = ev ? exp_q[0] : 6'd0;
    chk("out_valid", 8'(o_valid), 8'(ev));
    chk("busy",      8'(o_busy),  8'(ev));
    chk("dbg_state", 8'(o_dbg),   8'(ev));
    chk("out_pos",   8'(o_pos),   8'(b[1:0]));
    chk("out_seq",   8'(o_seq),   8'(b[3:2]));
    chk("out_last",  8'(o_last),  8'(b[4]));
    chk("out_empty", 8'(o_empty), 8'(b[5]));
    er = !ev || (out_ready && b[4]);
    chk("in_ready", 8'(o_in_ready), 8'(er));
    accepted = in_valid && er && resetn;
    if (ev && out_ready) begin
      log_q.push_back({o_empty, o_last, o_seq, o_pos});
      void'(exp_q.pop_front());
    end
    if (accepted) model_push(in_data, sel);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [3:0] v, input bit keep);
    in_valid = 1'b1;
    in_data  = v;
    accepted = 1'b0;
    for (int t = 0; t < 20 && !accepted; t++) tick();
    if (!accepted) chk("accept_timeout", 8'd0, 8'd1);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && exp_q.size() != 0; t++) tick();
    if (exp_q.size() != 0) chk("drain_timeout", 8'(exp_q.size()), 8'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [3:0] seen;
    int         nb;

    // Reset state of both instances
    @(negedge clk);
    tick();
    sel = 1'b1;
    tick();
    sel = 1'b0;
    resetn = 1'b1;
    @(negedge clk);

    // 1011 with out_ready=1: 0/0/0, 1/1/0, 3/2/1
    log_q.delete();
    send(4'b1011, 1'b0);
    drain();
    chk("v1011_count", 8'(log_q.size()), 8'd3);
    if (log_q.size() == 3) begin
      chk("v1011_b0", 8'(log_q[0]), 8'h00);
      chk("v1011_b1", 8'(log_q[1]), 8'h05);
      chk("v1011_b2", 8'(log_q[2]), 8'h1B);
    end

    // 1111 with out_ready toggling: stalls hold the beat
    log_q.delete();
    send(4'b1111, 1'b0);
    for (int i = 0; i < 8; i++) begin
      out_ready = (i % 2 == 0);
      tick();
    end
    out_ready = 1'b1;
    drain();
    chk("v1111_count", 8'(log_q.size()), 8'd4);
    if (log_q.size() == 4) begin
      chk("v1111_b0", 8'(log_q[0]), 8'h00);
      chk("v1111_b1", 8'(log_q[1]), 8'h05);
      chk("v1111_b2", 8'(log_q[2]), 8'h0A);
      chk("v1111_b3", 8'(log_q[3]), 8'h1F);
    end

    // Back-to-back 1000 then 0110, in_valid held high
    log_q.delete();
    send(4'b1000, 1'b1);
    send(4'b0110, 1'b0);
    chk("b2b_no_bubble", 8'(log_q.size()), 8'd1);
    drain();
    chk("b2b_count", 8'(log_q.size()), 8'd3);
    if (log_q.size() == 3) begin
      chk("b2b_b0", 8'(log_q[0]), 8'h13);
      chk("b2b_b1", 8'(log_q[1]), 8'h01);
      chk("b2b_b2", 8'(log_q[2]), 8'h16);
    end

    // Empty vector dropped (EMIT_EMPTY=0)
    log_q.delete();
    send(4'b0000, 1'b0);
    tick();
    tick();
    chk("empty_drop_count", 8'(log_q.size()), 8'd0);

    // Empty vector emitted (EMIT_EMPTY=1)
    sel = 1'b1;
    log_q.delete();
    send(4'b0000, 1'b0);
    drain();
    chk("empty_emit_count", 8'(log_q.size()), 8'd1);
    if (log_q.size() == 1) chk("empty_emit_beat", 8'(log_q[0]), 8'h30);
    sel = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-vector
    log_q.delete();
    send(4'b1110, 1'b0);
    tick();
    #1 resetn = 1'b0;
    #1;
    chk("rst_out_valid", 8'(o_valid), 8'd0);
    chk("rst_busy",      8'(o_busy),  8'd0);
    chk("rst_in_ready",  8'(o_in_ready), 8'd1);
    chk("rst_out_pos",   8'(o_pos),   8'd0);
    exp_q.delete();
    #1 resetn = 1'b1;
    @(negedge clk);
    log_q.delete();
    send(4'b0001, 1'b0);
    drain();
    chk("post_rst_count", 8'(log_q.size()), 8'd1);
    if (log_q.size() == 1) chk("post_rst_beat", 8'(log_q[0]), 8'h10);

    // Sweep 0..15 on EMIT_EMPTY=1 with random out_ready
    sel = 1'b1;
    rand_ready = 1'b1;
    for (int v = 0; v < 16; v++) begin
      log_q.delete();
      send(4'(v), 1'b0);
      drain();
      seen = 4'd0;
      nb = 0;
      for (int j = 0; j < log_q.size(); j++) begin
        if (!log_q[j][5]) seen[log_q[j][1:0]] = 1'b1;
        nb++;
      end
      chk("sweep_bits",  8'(seen), 8'(v));
      chk("sweep_beats", 8'(nb), 8'((v == 0) ? 1 : $countones(4'(v))));
    end
    out_ready = 1'b1;
    tick();
    sel = 1'b0;

    // Random vectors on EMIT_EMPTY=0, random gaps and back-to-back
    for (int r = 0; r < 40; r++) begin
      send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_valid = 1'b0;
    drain();
    rand_ready = 1'b0;
    out_ready = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bit_index_serializer.md
Name: bit_index_serializer

Overview:
- Downstream consumer of the 4-bit lowest-set-bit position encoder. Accepts a 4-bit request vector over a valid/ready handshake.
- Emits the 2-bit index of every set bit, one beat per set bit, lowest index first. Each beat carries a sequence number and a last flag.
- Feeds per-request dispatch logic that needs one index per cycle rather than a one-shot lowest position.

Parameters:
- EMIT_EMPTY, default 0. 0 = an all-zero vector is accepted and dropped with no output beat. 1 = an all-zero vector produces one beat with out_empty=1.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous, active-low reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a vector this cycle
- in_data  input  4  request vector
- out_valid  output  1  out_pos/out_seq/out_last/out_empty are valid
- out_ready  input  1  downstream accepts the current beat
- out_pos  output  2  index of the lowest remaining set bit
- out_seq  output  2  beat number within the current vector, starting at 0
- out_last  output  1  current beat is the final beat of the vector
- out_empty  output  1  beat represents an all-zero vector (EMIT_EMPTY=1 only)
- busy  output  1  a vector is held (state EMIT)

Behaviour:
- Clock and reset: one clock, clk. Reset resetn is asynchronous, active-low. While resetn=0, the state register is forced to IDLE immediately.
- Reset values: state=IDLE, mask=0, seq=0, empty_flag=0. Outputs: out_valid=0, out_pos=0, out_seq=0, out_last=0, out_empty=0, busy=0, in_ready=1.
- Registers: state (IDLE/EMIT), mask[3:0], seq[1:0], empty_flag.
- Outputs are combinational from the registers:
  - out_valid = (state==EMIT).
  - out_pos = lowest set bit index of mask, or 0 if mask==0.
  - out_last = empty_flag OR (mask has exactly one bit set).
  - out_seq = seq.
  - out_empty = empty_flag.
  - busy = (state==EMIT).
- in_ready = (state==IDLE) OR (out_valid AND out_ready AND out_last). A new vector can be accepted in the same cycle the last beat is consumed, giving back-to-back vectors with no bubble.
- Accept occurs when in_valid AND in_ready. On accept:
  - in_data != 0: mask <= in_data, seq <= 0, empty_flag <= 0, state <= EMIT.
  - in_data == 0 and EMIT_EMPTY=1: mask <= 0, seq <= 0, empty_flag <= 1, state <= EMIT.
  - in_data == 0 and EMIT_EMPTY=0: vector is dropped; state <= IDLE. If this accept coincides with a last-beat handshake, the block goes to IDLE.
- Latency: a vector accepted at edge N has its first beat visible (out_valid=1) after edge N.
- Beat handshake (out_valid AND out_ready), not last: clear the lowest set bit of mask; seq <= seq+1. State stays EMIT.
- Last-beat handshake with no simultaneous accept: mask <= 0, seq <= 0, empty_flag <= 0, state <= IDLE.
- Stall (out_valid=1, out_ready=0): all out_* signals are held stable. in_ready=0 and in_data is ignored.
- seq never exceeds 3, because a vector has at most 4 beats. No wrap occurs.
- in_valid while in_ready=0: no accept. The upstream side must hold its data.
- Reset asserted mid-vector: the remaining beats are discarded and no partial beat is emitted after reset.
- Number of beats per vector = popcount(in_data), or 1 for an empty vector with EMIT_EMPTY=1.

Test Plan:
- Reset, then in_data=4'b1011 with out_ready=1 -> beats pos/seq/last = 0/0/0, 1/1/0, 3/2/1 on consecutive cycles; in_ready=1 in the cycle of the last beat.
- in_data=4'b1111 with out_ready toggling 1,0,1,0 -> out_pos and out_seq are held during stall cycles; sequence is pos 0,1,2,3 with out_last only on pos 3.
- Back-to-back vectors 4'b1000 then 4'b0110 with in_valid held high and out_ready=1 -> beats pos 3 (last), then pos 1, then pos 2 (last), with no idle cycle between the vectors.
- in_data=4'b0000: with EMIT_EMPTY=0, no out_valid and in_ready stays 1; with EMIT_EMPTY=1, one beat pos=0, empty=1, last=1, seq=0.
- Accept 4'b1110, consume one beat (pos 1), then pulse resetn=0 asynchronously mid-cycle -> out_valid drops immediately, busy=0; the next vector 4'b0001 emits pos 0, seq 0, last 1.
- Exhaustive sweep of in_data 0..15 (EMIT_EMPTY=1) with random out_ready -> the collected positions equal the set-bit indices in ascending order, and the beat count equals popcount (1 for 0).
